// File: rtl/dice_bram_port_arbiter_if.sv
// Bus bundle between the DICE requesters / BRAM pair and the port arbiter.
// The slave side is the arbiter. The master side is the requesters plus the BRAM.
interface dice_bram_port_arbiter_if #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int BYTE_LANES = DATA_W / 8
);
  logic                  bram_ready;
  logic                  grad_done;
  logic                  grad_en;
  logic                  grad_we;
  logic [ADDR_W-1:0]     grad_addr;
  logic [DATA_W-1:0]     grad_din;
  logic                  gamma_en_ref;
  logic [ADDR_W-1:0]     gamma_addr_ref;
  logic                  gamma_en_def;
  logic [ADDR_W-1:0]     gamma_addr_def;
  logic [DATA_W-1:0]     bram_dout_ref;
  logic [DATA_W-1:0]     bram_dout_def;
  logic                  bram_en_ref;
  logic [BYTE_LANES-1:0] bram_we_ref;
  logic [31:0]           bram_addr_ref;
  logic [DATA_W-1:0]     bram_din_ref;
  logic                  bram_en_def;
  logic [31:0]           bram_addr_def;
  logic [DATA_W-1:0]     rdata_ref;
  logic                  rvalid_ref;
  logic [DATA_W-1:0]     rdata_def;
  logic                  rvalid_def;
  logic [1:0]            phase;
  logic                  access_err;

  modport master (
    output bram_ready, grad_done, grad_en, grad_we, grad_addr, grad_din,
           gamma_en_ref, gamma_addr_ref, gamma_en_def, gamma_addr_def,
           bram_dout_ref, bram_dout_def,
    input  bram_en_ref, bram_we_ref, bram_addr_ref, bram_din_ref,
           bram_en_def, bram_addr_def, rdata_ref, rvalid_ref,
           rdata_def, rvalid_def, phase, access_err
  );

  modport slave (
    input  bram_ready, grad_done, grad_en, grad_we, grad_addr, grad_din,
           gamma_en_ref, gamma_addr_ref, gamma_en_def, gamma_addr_def,
           bram_dout_ref, bram_dout_def,
    output bram_en_ref, bram_we_ref, bram_addr_ref, bram_din_ref,
           bram_en_def, bram_addr_def, rdata_ref, rvalid_ref,
           rdata_def, rvalid_def, phase, access_err
  );
endinterface

// File: rtl/dice_bram_port_arbiter.sv
// Ownership arbiter for the ref/def image BRAM ports.
// The gradient engine owns ref in GRAD. The gamma engine owns both ports in GAMMA. DRAIN separates the two phases.
module dice_bram_port_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int BYTE_LANES = DATA_W / 8,
  parameter int RD_LATENCY = 2
) (
  input  logic clock,
  input  logic resetn,
  dice_bram_port_arbiter_if.slave bus
);
  localparam int SHIFT = $clog2(BYTE_LANES);
  localparam int CNT_W = $clog2(RD_LATENCY + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, GRAD = 2'd1, DRAIN = 2'd2, GAMMA = 2'd3} phase_e;

  phase_e                phase_q, phase_d, tgt_q, tgt_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  en_ref_q, en_ref_d, en_def_q, en_def_d;
  logic [BYTE_LANES-1:0] we_ref_q, we_ref_d;
  logic [31:0]           addr_ref_q, addr_ref_d, addr_def_q, addr_def_d;
  logic [DATA_W-1:0]     din_ref_q, din_ref_d;
  logic                  err_q, err_d;
  logic [RD_LATENCY-1:0] vld_pipe_ref_q, vld_pipe_ref_d, vld_pipe_def_q, vld_pipe_def_d;
  logic [DATA_W-1:0]     hold_ref_q, hold_ref_d, hold_def_q, hold_def_d;
  logic                  stay, gnt_grad, gnt_gref, gnt_gdef, rv_ref, rv_def;

  function automatic logic [31:0] byte_addr(input logic [ADDR_W-1:0] w);
    return 32'(w) << SHIFT;
  endfunction

  assign rv_ref = vld_pipe_ref_q[RD_LATENCY-1];
  assign rv_def = vld_pipe_def_q[RD_LATENCY-1];

  always_comb begin
    phase_d = phase_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    case (phase_q)
      IDLE:  if (bus.bram_ready) phase_d = bus.grad_done ? GAMMA : GRAD;
      GRAD:  if (bus.grad_done) begin
               phase_d = DRAIN;
               tgt_d   = GAMMA;
               cnt_d   = CNT_W'(RD_LATENCY - 1);
             end
      GAMMA: if (!bus.grad_done) begin
               phase_d = DRAIN;
               tgt_d   = GRAD;
               cnt_d   = CNT_W'(RD_LATENCY - 1);
             end
      default: begin
        if (cnt_q == '0) phase_d = tgt_q;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
    endcase
    if (!bus.bram_ready) phase_d = IDLE;

    // Grants happen only when the phase is held across the edge, so DRAIN and IDLE always show idle ports.
    stay     = (phase_d == phase_q);
    gnt_grad = stay && (phase_q == GRAD)  && bus.grad_en;
    gnt_gref = stay && (phase_q == GAMMA) && bus.gamma_en_ref;
    gnt_gdef = stay && (phase_q == GAMMA) && bus.gamma_en_def;

    en_ref_d   = gnt_grad || gnt_gref;
    en_def_d   = gnt_gdef;
    we_ref_d   = {BYTE_LANES{gnt_grad && bus.grad_we}};
    addr_ref_d = addr_ref_q;
    if (gnt_grad)      addr_ref_d = byte_addr(bus.grad_addr);
    else if (gnt_gref) addr_ref_d = byte_addr(bus.gamma_addr_ref);
    addr_def_d = gnt_gdef ? byte_addr(bus.gamma_addr_def) : addr_def_q;
    din_ref_d  = (gnt_grad && bus.grad_we) ? bus.grad_din : din_ref_q;

    err_d = err_q
          || (bus.grad_en && (phase_q != GRAD))
          || ((bus.gamma_en_ref || bus.gamma_en_def) && (phase_q != GAMMA));

    // The pipes are fed from the registered port enables, so rvalid trails bram_en by RD_LATENCY cycles.
    vld_pipe_ref_d = RD_LATENCY'({vld_pipe_ref_q, en_ref_q && !we_ref_q[0]});
    vld_pipe_def_d = RD_LATENCY'({vld_pipe_def_q, en_def_q});
    if (!bus.bram_ready) begin
      vld_pipe_ref_d = '0;
      vld_pipe_def_d = '0;
    end

    hold_ref_d = rv_ref ? bus.bram_dout_ref : hold_ref_q;
    hold_def_d = rv_def ? bus.bram_dout_def : hold_def_q;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      phase_q        <= IDLE;
      tgt_q          <= IDLE;
      cnt_q          <= '0;
      en_ref_q       <= 1'b0;
      en_def_q       <= 1'b0;
      we_ref_q       <= '0;
      addr_ref_q     <= '0;
      addr_def_q     <= '0;
      din_ref_q      <= '0;
      err_q          <= 1'b0;
      vld_pipe_ref_q <= '0;
      vld_pipe_def_q <= '0;
      hold_ref_q     <= '0;
      hold_def_q     <= '0;
    end else begin
      phase_q        <= phase_d;
      tgt_q          <= tgt_d;
      cnt_q          <= cnt_d;
      en_ref_q       <= en_ref_d;
      en_def_q       <= en_def_d;
      we_ref_q       <= we_ref_d;
      addr_ref_q     <= addr_ref_d;
      addr_def_q     <= addr_def_d;
      din_ref_q      <= din_ref_d;
      err_q          <= err_d;
      vld_pipe_ref_q <= vld_pipe_ref_d;
      vld_pipe_def_q <= vld_pipe_def_d;
      hold_ref_q     <= hold_ref_d;
      hold_def_q     <= hold_def_d;
    end
  end

  assign bus.bram_en_ref   = en_ref_q;
  assign bus.bram_we_ref   = we_ref_q;
  assign bus.bram_addr_ref = addr_ref_q;
  assign bus.bram_din_ref  = din_ref_q;
  assign bus.bram_en_def   = en_def_q;
  assign bus.bram_addr_def = addr_def_q;
  assign bus.rvalid_ref    = rv_ref;
  assign bus.rvalid_def    = rv_def;
  // Read data passes straight through on the valid cycle and is held in between.
  assign bus.rdata_ref     = rv_ref ? bus.bram_dout_ref : hold_ref_q;
  assign bus.rdata_def     = rv_def ? bus.bram_dout_def : hold_def_q;
  assign bus.phase         = phase_q;
  assign bus.access_err    = err_q;
endmodule

// File: tb/tb_dice_bram_port_arbiter.sv
// Drives two arbiter configurations (32b/latency 2 and 64b/latency 3) with shared stimulus.
// Each configuration is checked every cycle against a behavioural model, plus directed literal expectations.
module tb_dice_bram_port_arbiter;
  logic        clock = 1'b0;
  logic        s_resetn, s_ready, s_done, s_grad_en, s_grad_we, s_ger, s_ged;
  logic [11:0] s_grad_addr, s_gar, s_gad;
  logic [63:0] s_grad_din, s_dout_ref, s_dout_def;
  int          checks = 0;
  int          errors = 0;

  always #5 clock = ~clock;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g
    localparam int DW = (gi == 0) ? 32 : 64;
    localparam int L  = (gi == 0) ? 2 : 3;
    localparam int BL = DW / 8;

    dice_bram_port_arbiter_if #(.ADDR_W(12), .DATA_W(DW)) bus ();

    assign bus.bram_ready     = s_ready;
    assign bus.grad_done      = s_done;
    assign bus.grad_en        = s_grad_en;
    assign bus.grad_we        = s_grad_we;
    assign bus.grad_addr      = s_grad_addr;
    assign bus.grad_din       = s_grad_din[DW-1:0];
    assign bus.gamma_en_ref   = s_ger;
    assign bus.gamma_addr_ref = s_gar;
    assign bus.gamma_en_def   = s_ged;
    assign bus.gamma_addr_def = s_gad;
    assign bus.bram_dout_ref  = s_dout_ref[DW-1:0];
    assign bus.bram_dout_def  = s_dout_def[DW-1:0];

    dice_bram_port_arbiter #(.ADDR_W(12), .DATA_W(DW), .RD_LATENCY(L)) dut (
      .clock (clock),
      .resetn(s_resetn),
      .bus   (bus)
    );

    // Model: the phase is an integer, DRAIN ends at an absolute cycle number, and each read is a queued due-cycle.
    int unsigned cyc = 0;
    int unsigned dend = 0;
    int          ph = 0;
    int          tgt = 0;
    bit          live = 0;
    bit          en_r, en_d, err, rv_r, rv_d;
    logic [BL-1:0] we;
    logic [31:0]   ar, ad;
    logic [DW-1:0] din, hr, hd;
    int unsigned   qr[$], qd[$];

    always @(posedge clock) begin
      int nxt;
      bit own;
      cyc++;
      if (!s_resetn) begin
        ph = 0; tgt = 0; en_r = 0; en_d = 0; err = 0; rv_r = 0; rv_d = 0;
        we = '0; ar = '0; ad = '0; din = '0; hr = '0; hd = '0;
        qr.delete(); qd.delete();
        live = 1;
      end else begin
        nxt = ph;
        if (s_grad_en && ph != 1) err = 1;
        if ((s_ger || s_ged) && ph != 3) err = 1;
        case (ph)
          0: if (s_ready) nxt = s_done ? 3 : 1;
          1: if (s_done)  begin nxt = 2; tgt = 3; dend = cyc + L; end
          3: if (!s_done) begin nxt = 2; tgt = 1; dend = cyc + L; end
          default: if (cyc == dend) nxt = tgt;
        endcase
        if (!s_ready) begin nxt = 0; qr.delete(); qd.delete(); end
        own  = (nxt == ph);
        en_r = own && ((ph == 1 && s_grad_en) || (ph == 3 && s_ger));
        en_d = own && ph == 3 && s_ged;
        we   = (own && ph == 1 && s_grad_en && s_grad_we) ? '1 : '0;
        if (en_r) ar = 32'(ph == 1 ? s_grad_addr : s_gar) * BL;
        if (en_d) ad = 32'(s_gad) * BL;
        if (we[0]) din = s_grad_din[DW-1:0];
        if (en_r && !we[0]) qr.push_back(cyc + L);
        if (en_d) qd.push_back(cyc + L);
        rv_r = (qr.size() > 0) && (qr[0] == cyc);
        if (rv_r) void'(qr.pop_front());
        rv_d = (qd.size() > 0) && (qd[0] == cyc);
        if (rv_d) void'(qd.pop_front());
        ph = nxt;
      end
    end

    always @(negedge clock) begin
      logic [DW-1:0] er, ed;
      if (live) begin
        er = rv_r ? s_dout_ref[DW-1:0] : hr;
        ed = rv_d ? s_dout_def[DW-1:0] : hd;
        chk($sformatf("c%0d.phase", gi),      64'(bus.phase),         64'(ph));
        chk($sformatf("c%0d.en_ref", gi),     64'(bus.bram_en_ref),   64'(en_r));
        chk($sformatf("c%0d.we_ref", gi),     64'(bus.bram_we_ref),   64'(we));
        chk($sformatf("c%0d.addr_ref", gi),   64'(bus.bram_addr_ref), 64'(ar));
        chk($sformatf("c%0d.din_ref", gi),    64'(bus.bram_din_ref),  64'(din));
        chk($sformatf("c%0d.en_def", gi),     64'(bus.bram_en_def),   64'(en_d));
        chk($sformatf("c%0d.addr_def", gi),   64'(bus.bram_addr_def), 64'(ad));
        chk($sformatf("c%0d.rvalid_ref", gi), 64'(bus.rvalid_ref),    64'(rv_r));
        chk($sformatf("c%0d.rdata_ref", gi),  64'(bus.rdata_ref),     64'(er));
        chk($sformatf("c%0d.rvalid_def", gi), 64'(bus.rvalid_def),    64'(rv_d));
        chk($sformatf("c%0d.rdata_def", gi),  64'(bus.rdata_def),     64'(ed));
        chk($sformatf("c%0d.access_err", gi), 64'(bus.access_err),    64'(err));
        if (rv_r) hr = s_dout_ref[DW-1:0];
        if (rv_d) hd = s_dout_def[DW-1:0];
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  initial begin
    s_resetn = 0; s_ready = 0; s_done = 0; s_grad_en = 0; s_grad_we = 0;
    s_ger = 0; s_ged = 0; s_grad_addr = '0; s_gar = '0; s_gad = '0;
    s_grad_din = '0; s_dout_ref = '0; s_dout_def = '0;
    tick(); tick();
    chk("rst.phase",  64'(g[0].bus.phase), 64'd0);
    chk("rst.en_ref", 64'(g[0].bus.bram_en_ref), 64'd0);
    chk("rst.err",    64'(g[0].bus.access_err), 64'd0);
    chk("rst.c1.phase", 64'(g[1].bus.phase), 64'd0);

    s_resetn = 1; s_ready = 1; s_done = 0;
    tick();
    chk("idle2grad", 64'(g[0].bus.phase), 64'd1);

    s_grad_en = 1; s_grad_we = 1; s_grad_addr = 12'h041; s_grad_din = 64'hDEADBEEF;
    tick();
    chk("wr.en",      64'(g[0].bus.bram_en_ref), 64'd1);
    chk("wr.we",      64'(g[0].bus.bram_we_ref), 64'hF);
    chk("wr.addr",    64'(g[0].bus.bram_addr_ref), 64'h104);
    chk("wr.din",     64'(g[0].bus.bram_din_ref), 64'hDEADBEEF);
    chk("wr.rvalid",  64'(g[0].bus.rvalid_ref), 64'd0);
    chk("wr.err",     64'(g[0].bus.access_err), 64'd0);
    chk("c1.wr.we",   64'(g[1].bus.bram_we_ref), 64'hFF);
    chk("c1.wr.addr", 64'(g[1].bus.bram_addr_ref), 64'h208);

    s_grad_we = 0; s_grad_addr = 12'h3FF; s_dout_ref = 64'h12345678;
    tick();
    chk("rd.addr",    64'(g[0].bus.bram_addr_ref), 64'hFFC);
    chk("rd.we",      64'(g[0].bus.bram_we_ref), 64'h0);
    chk("c1.rd.addr", 64'(g[1].bus.bram_addr_ref), 64'h1FF8);
    s_grad_en = 0;
    tick();
    chk("rd.lat1", 64'(g[0].bus.rvalid_ref), 64'd0);
    tick();
    chk("rd.lat2",   64'(g[0].bus.rvalid_ref), 64'd1);
    chk("rd.data",   64'(g[0].bus.rdata_ref), 64'h12345678);
    chk("c1.rd.lat2", 64'(g[1].bus.rvalid_ref), 64'd0);
    tick();
    chk("rd.pulse",   64'(g[0].bus.rvalid_ref), 64'd0);
    chk("c1.rd.lat3", 64'(g[1].bus.rvalid_ref), 64'd1);
    chk("c1.rd.data", 64'(g[1].bus.rdata_ref), 64'h12345678);

    s_ged = 1;
    tick();
    chk("err.set",   64'(g[0].bus.access_err), 64'd1);
    chk("err.endef", 64'(g[0].bus.bram_en_def), 64'd0);
    s_ged = 0; s_done = 1;
    tick();
    chk("drain.1",  64'(g[0].bus.phase), 64'd2);
    chk("drain.en", 64'(g[0].bus.bram_en_ref), 64'd0);
    tick();
    chk("drain.2", 64'(g[0].bus.phase), 64'd2);
    tick();
    chk("gamma",       64'(g[0].bus.phase), 64'd3);
    chk("c1.drain.3",  64'(g[1].bus.phase), 64'd2);
    tick();
    chk("c1.gamma", 64'(g[1].bus.phase), 64'd3);

    s_ger = 1; s_gar = 12'hBFE; s_ged = 1; s_gad = 12'h47E;
    tick();
    chk("gam.addr_ref",    64'(g[0].bus.bram_addr_ref), 64'h2FF8);
    chk("gam.addr_def",    64'(g[0].bus.bram_addr_def), 64'h11F8);
    chk("gam.we",          64'(g[0].bus.bram_we_ref), 64'h0);
    chk("c1.gam.addr_ref", 64'(g[1].bus.bram_addr_ref), 64'h5FF0);
    s_ger = 0; s_ged = 0;
    s_dout_ref = 64'h1122334455667788; s_dout_def = 64'h99AABBCCDDEEFF00;
    tick(); tick();
    chk("gam.rv_ref", 64'(g[0].bus.rvalid_ref), 64'd1);
    chk("gam.rv_def", 64'(g[0].bus.rvalid_def), 64'd1);
    chk("gam.rd_def", 64'(g[0].bus.rdata_def), 64'hDDEEFF00);
    tick();
    chk("gam.hold",      64'(g[0].bus.rdata_ref), 64'h55667788);
    chk("c1.gam.rd_ref", 64'(g[1].bus.rdata_ref), 64'h1122334455667788);

    for (int i = 0; i < 5; i++) begin
      s_ged = 1; s_gad = 12'(i + 16); s_dout_def = 64'(i * 7 + 3);
      tick();
    end
    s_ged = 0; s_ready = 0;
    tick();
    chk("drop.phase",  64'(g[0].bus.phase), 64'd0);
    chk("drop.en_def", 64'(g[0].bus.bram_en_def), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk("drop.rv_def",    64'(g[0].bus.rvalid_def), 64'd0);
      chk("c1.drop.rv_def", 64'(g[1].bus.rvalid_def), 64'd0);
      tick();
    end
    chk("err.sticky", 64'(g[0].bus.access_err), 64'd1);
    s_ready = 1; s_resetn = 0;
    tick();
    chk("err.clear", 64'(g[0].bus.access_err), 64'd0);
    s_resetn = 1;

    for (int i = 0; i < 3000; i++) begin
      s_resetn    = ($urandom_range(0, 199) != 0);
      s_ready     = ($urandom_range(0, 29) != 0);
      if ($urandom_range(0, 24) == 0) s_done = ~s_done;
      s_grad_en   = ($urandom_range(0, 2) == 0);
      s_grad_we   = $urandom_range(0, 1) == 1;
      s_grad_addr = 12'($urandom);
      s_grad_din  = {$urandom, $urandom};
      s_ger       = ($urandom_range(0, 2) == 0);
      s_ged       = ($urandom_range(0, 2) == 0);
      s_gar       = 12'($urandom);
      s_gad       = 12'($urandom);
      s_dout_ref  = {$urandom, $urandom};
      s_dout_def  = {$urandom, $urandom};
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
